// File: rtl/tblock_distributor.sv
// Thread-block distributor: round-robin allocation to clusters with a free warp,
// and a round-robin merge of per-cluster done reports into one buffered stream.
// Optional perf counters are enabled by defining TBLOCK_DISTRIBUTOR_PERF_EN.
module tblock_distributor #(
    parameter int NumClusters   = 4,
    parameter int PcWidth       = 16,
    parameter int AddressWidth  = 32,
    parameter int TblockIdxBits = 8,
    parameter int TgroupIdBits  = 8,
    parameter int DoneFifoDepth = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,

    output logic                                  warp_free_o,
    input  logic                                  allocate_warp_i,
    input  logic [PcWidth-1:0]                    allocate_pc_i,
    input  logic [AddressWidth-1:0]               allocate_dp_addr_i,
    input  logic [TblockIdxBits-1:0]              allocate_tblock_idx_i,
    input  logic [TgroupIdBits-1:0]               allocate_tgroup_id_i,

    input  logic [NumClusters-1:0]                cl_warp_free_i,
    output logic [NumClusters-1:0]                cl_allocate_warp_o,
    output logic [PcWidth-1:0]                    cl_allocate_pc_o,
    output logic [AddressWidth-1:0]               cl_allocate_dp_addr_o,
    output logic [TblockIdxBits-1:0]              cl_allocate_tblock_idx_o,
    output logic [TgroupIdBits-1:0]               cl_allocate_tgroup_id_o,

    input  logic [NumClusters-1:0]                cl_tblock_done_i,
    input  logic [NumClusters*TgroupIdBits-1:0]   cl_tblock_done_id_i,
    output logic [NumClusters-1:0]                cl_tblock_done_ready_o,

    output logic                                  tblock_done_o,
    output logic [TgroupIdBits-1:0]               tblock_done_id_o,
    input  logic                                  tblock_done_ready_i,

    output logic [31:0]                           perf_dispatched_o,
    output logic [31:0]                           perf_done_o
);

    localparam int RrW  = (NumClusters > 1) ? $clog2(NumClusters) : 1;
    localparam int PtrW = $clog2(DoneFifoDepth);
    localparam int CntW = PtrW + 1;

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    function automatic logic [RrW:0] rr_pick(input logic [NumClusters-1:0] req,
                                             input logic [RrW-1:0] ptr);
        logic         found;
        logic [RrW-1:0] idx;
        logic [RrW-1:0] cand;
        int           tmp;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NumClusters; k++) begin
            tmp = int'(ptr) + k;
            if (tmp >= NumClusters) tmp = tmp - NumClusters;
            cand = RrW'(tmp);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [RrW-1:0] rr_next(input logic [RrW-1:0] idx);
        if (int'(idx) >= NumClusters - 1) return '0;
        return idx + 1'b1;
    endfunction

    // ---------------- allocation ----------------
    logic [RrW-1:0]         alloc_rr_q;
    logic [NumClusters-1:0] eligible;
    logic [RrW:0]           alloc_pick;
    logic [RrW-1:0]         alloc_sel;
    logic [NumClusters-1:0] alloc_onehot;
    logic                   alloc_accept;

    // A just-pulsed cluster still reports free this cycle, so it is masked out.
    assign eligible     = cl_warp_free_i & ~cl_allocate_warp_o;
    assign warp_free_o  = ~rst_i & (|eligible);
    assign alloc_accept = allocate_warp_i & warp_free_o;
    assign alloc_pick   = rr_pick(eligible, alloc_rr_q);
    assign alloc_sel    = alloc_pick[RrW-1:0];

    always_comb begin
        alloc_onehot            = '0;
        alloc_onehot[alloc_sel] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_rr_q               <= '0;
            cl_allocate_warp_o       <= '0;
            cl_allocate_pc_o         <= '0;
            cl_allocate_dp_addr_o    <= '0;
            cl_allocate_tblock_idx_o <= '0;
            cl_allocate_tgroup_id_o  <= '0;
        end else begin
            cl_allocate_warp_o <= '0;
            if (alloc_accept) begin
                cl_allocate_warp_o       <= alloc_onehot;
                cl_allocate_pc_o         <= allocate_pc_i;
                cl_allocate_dp_addr_o    <= allocate_dp_addr_i;
                cl_allocate_tblock_idx_o <= allocate_tblock_idx_i;
                cl_allocate_tgroup_id_o  <= allocate_tgroup_id_i;
                alloc_rr_q               <= rr_next(alloc_sel);
            end
        end
    end

    // ---------------- done merge ----------------
    logic [TgroupIdBits-1:0] done_id [NumClusters];
    logic [RrW-1:0]          done_rr_q;
    logic [RrW:0]            done_pick;
    logic [RrW-1:0]          done_sel;
    logic                    done_found;

    for (genvar j = 0; j < NumClusters; j++) begin : g_done_id
        assign done_id[j] = cl_tblock_done_id_i[j*TgroupIdBits +: TgroupIdBits];
    end

    logic [TgroupIdBits-1:0] fifo_mem [DoneFifoDepth];
    logic [PtrW-1:0]         wr_ptr_q;
    logic [PtrW-1:0]         rd_ptr_q;
    logic [CntW-1:0]         count_q;
    logic                    full;
    logic                    push;
    logic                    pop;

    assign done_pick  = rr_pick(cl_tblock_done_i, done_rr_q);
    assign done_found = done_pick[RrW];
    assign done_sel   = done_pick[RrW-1:0];
    assign full       = (count_q == CntW'(DoneFifoDepth));

    // Grant depends only on the current full flag; a same-cycle pop never frees a slot.
    always_comb begin
        cl_tblock_done_ready_o = '0;
        if (!rst_i && done_found && !full) cl_tblock_done_ready_o[done_sel] = 1'b1;
    end

    assign push             = |cl_tblock_done_ready_o;
    assign tblock_done_o    = ~rst_i & (count_q != '0);
    assign tblock_done_id_o = tblock_done_o ? fifo_mem[rd_ptr_q] : '0;
    assign pop              = tblock_done_o & tblock_done_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= done_id[done_sel];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_rr_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + 1'b1;
                done_rr_q <= rr_next(done_sel);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    // ---------------- perf counters ----------------
`ifdef TBLOCK_DISTRIBUTOR_PERF_EN
    logic [31:0] perf_dispatched_q;
    logic [31:0] perf_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_dispatched_q <= '0;
            perf_done_q       <= '0;
        end else begin
            if (alloc_accept && perf_dispatched_q != '1) perf_dispatched_q <= perf_dispatched_q + 1'b1;
            if (pop && perf_done_q != '1)                perf_done_q       <= perf_done_q + 1'b1;
        end
    end

    assign perf_dispatched_o = perf_dispatched_q;
    assign perf_done_o       = perf_done_q;
`else
    assign perf_dispatched_o = '0;
    assign perf_done_o       = '0;
`endif

endmodule

// File: tb/tb_tblock_distributor.sv
// Randomized + directed bench for tblock_distributor against a queue-based reference model.
module tb_tblock_distributor;

    localparam int N = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        warp_free;
    logic        allocate_warp;
    logic [15:0] alloc_pc;
    logic [31:0] alloc_dp;
    logic [7:0]  alloc_tbi;
    logic [7:0]  alloc_tgi;
    logic [N-1:0] cl_warp_free;
    logic [N-1:0] cl_alloc;
    logic [15:0] cl_pc;
    logic [31:0] cl_dp;
    logic [7:0]  cl_tbi;
    logic [7:0]  cl_tgi;
    logic [N-1:0] cl_done;
    logic [N*8-1:0] cl_done_id;
    logic [N-1:0] cl_done_rdy;
    logic        done_v;
    logic [7:0]  done_id;
    logic        done_rdy;
    logic [31:0] perf_disp;
    logic [31:0] perf_done;

    always #5 clk = ~clk;

    tblock_distributor dut (
        .clk_i(clk), .rst_i(rst),
        .warp_free_o(warp_free), .allocate_warp_i(allocate_warp),
        .allocate_pc_i(alloc_pc), .allocate_dp_addr_i(alloc_dp),
        .allocate_tblock_idx_i(alloc_tbi), .allocate_tgroup_id_i(alloc_tgi),
        .cl_warp_free_i(cl_warp_free), .cl_allocate_warp_o(cl_alloc),
        .cl_allocate_pc_o(cl_pc), .cl_allocate_dp_addr_o(cl_dp),
        .cl_allocate_tblock_idx_o(cl_tbi), .cl_allocate_tgroup_id_o(cl_tgi),
        .cl_tblock_done_i(cl_done), .cl_tblock_done_id_i(cl_done_id),
        .cl_tblock_done_ready_o(cl_done_rdy),
        .tblock_done_o(done_v), .tblock_done_id_o(done_id), .tblock_done_ready_i(done_rdy),
        .perf_dispatched_o(perf_disp), .perf_done_o(perf_done)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    int           m_rr = 0, m_drr = 0;
    logic [N-1:0] m_pulse = '0;
    logic [15:0]  m_pc = '0;
    logic [31:0]  m_dp = '0;
    logic [7:0]   m_tbi = '0, m_tgi = '0;
    int unsigned  m_disp = 0, m_ndone = 0;
    logic [7:0]   q[$];
    logic [N-1:0] last_rdy = '0;

    // One clock: check combinational outputs, advance the model, then check registers.
    task automatic step();
        logic [N-1:0] elig, exp_rdy;
        int sel, g;
        bit wf, exp_v, do_pop;
        #1;
        elig = cl_warp_free & ~m_pulse;
        wf = !rst && (elig != 0);
        chk("warp_free", warp_free, wf);
        g = -1;
        for (int k = 0; k < N; k++) if (g < 0 && cl_done[(m_drr + k) % N]) g = (m_drr + k) % N;
        exp_rdy = '0;
        if (!rst && g >= 0 && q.size() < D) exp_rdy[g] = 1'b1;
        chk("done_ready", cl_done_rdy, exp_rdy);
        exp_v = !rst && q.size() > 0;
        chk("done_valid", done_v, exp_v);
        if (exp_v) chk("done_id", done_id, q[0]);
        last_rdy = exp_rdy;
        if (rst) begin
            m_rr = 0; m_drr = 0; m_pulse = '0;
            m_pc = '0; m_dp = '0; m_tbi = '0; m_tgi = '0;
            m_disp = 0; m_ndone = 0; q.delete();
        end else begin
            m_pulse = '0;
            if (allocate_warp && wf) begin
                sel = -1;
                for (int k = 0; k < N; k++) if (sel < 0 && elig[(m_rr + k) % N]) sel = (m_rr + k) % N;
                m_pulse[sel] = 1'b1;
                m_pc = alloc_pc; m_dp = alloc_dp; m_tbi = alloc_tbi; m_tgi = alloc_tgi;
                m_rr = (sel + 1) % N;
                m_disp++;
            end
            do_pop = exp_v && done_rdy;
            if (do_pop) begin
                void'(q.pop_front());
                m_ndone++;
            end
            if (exp_rdy != 0) begin
                q.push_back(cl_done_id[g*8 +: 8]);
                m_drr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        chk("alloc_pulse", cl_alloc, m_pulse);
        chk("alloc_pc", cl_pc, m_pc);
        chk("alloc_dp", cl_dp, m_dp);
        chk("alloc_tbi", cl_tbi, m_tbi);
        chk("alloc_tgi", cl_tgi, m_tgi);
`ifdef TBLOCK_DISTRIBUTOR_PERF_EN
        chk("perf_disp", perf_disp, m_disp);
        chk("perf_done", perf_done, m_ndone);
`else
        chk("perf_disp", perf_disp, 0);
        chk("perf_done", perf_done, 0);
`endif
    endtask

    task automatic rand_payload();
        alloc_pc  = 16'($urandom);
        alloc_dp  = $urandom;
        alloc_tbi = 8'($urandom);
        alloc_tgi = 8'($urandom);
    endtask

    initial begin
        int acc;
        rst = 1'b1; allocate_warp = 1'b0; cl_warp_free = '0;
        cl_done = '0; cl_done_id = '0; done_rdy = 1'b0;
        rand_payload();
        step(); step();
        rst = 1'b0;

        // round-robin allocation over all-free clusters
        cl_warp_free = 4'hF;
        for (int i = 0; i < 4; i++) begin
            allocate_warp = 1'b1; rand_payload(); step();
        end
        allocate_warp = 1'b0; step();

        // skipping and masking
        cl_warp_free = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            allocate_warp = 1'b1; rand_payload(); step();
        end
        cl_warp_free = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            allocate_warp = 1'b1; rand_payload(); step();
        end
        allocate_warp = 1'b0; step();

        // simultaneous done reports
        done_rdy = 1'b1;
        cl_done = 4'hF; cl_done_id = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 6; i++) begin
            step(); cl_done = cl_done & ~last_rdy;
        end

        // full FIFO with a single reporting cluster
        done_rdy = 1'b0; acc = 0;
        cl_done = 4'b0010; cl_done_id[15:8] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_rdy[1]) begin
                acc++;
                cl_done_id[15:8] = 8'($urandom);
                if (acc == 6) cl_done = '0;
            end
        end
        chk("full_accepts", acc, 4);
        done_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_rdy[1]) begin
                acc++;
                cl_done_id[15:8] = 8'($urandom);
                if (acc == 6) cl_done = '0;
            end
        end
        chk("full_total", acc, 6);

        // reset mid-flight with a pending pulse and three queued entries
        done_rdy = 1'b0; cl_warp_free = 4'hF;
        cl_done = 4'b0111; cl_done_id = 32'h00_22_21_20;
        for (int i = 0; i < 3; i++) begin
            allocate_warp = (i == 2); rand_payload();
            step(); cl_done = cl_done & ~last_rdy;
        end
        allocate_warp = 1'b0; rst = 1'b1; step();
        rst = 1'b0; step();

        // randomized traffic with held-valid done handshakes
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            allocate_warp = $urandom_range(0, 1);
            rand_payload();
            cl_warp_free = 4'($urandom);
            done_rdy = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < N; j++) begin
                if (last_rdy[j]) cl_done[j] = 1'b0;
                if (!cl_done[j] && $urandom_range(0, 2) == 0) begin
                    cl_done[j] = 1'b1;
                    cl_done_id[j*8 +: 8] = 8'($urandom);
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
